// File: rtl/croc_pkg.sv
// Shared address-map types and constants for the Croc peripheral interconnect.
package croc_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam int unsigned NumPeriphRules = 5;

    localparam logic [31:0] ObiErrRdata = 32'hBADC_AB1E;

    // Subordinate index 0 is reserved for the internal error responder.
    localparam logic [31:0] PeriphDebug   = 32'd1;
    localparam logic [31:0] PeriphSocCtrl = 32'd2;
    localparam logic [31:0] PeriphUart    = 32'd3;
    localparam logic [31:0] PeriphGpio    = 32'd4;
    localparam logic [31:0] PeriphTimer   = 32'd5;

    localparam addr_map_rule_t [NumPeriphRules-1:0] periph_addr_map = '{
        '{idx: PeriphTimer,   start_addr: 32'h0300_A000, end_addr: 32'h0300_B000},
        '{idx: PeriphGpio,    start_addr: 32'h0300_5000, end_addr: 32'h0300_6000},
        '{idx: PeriphUart,    start_addr: 32'h0300_2000, end_addr: 32'h0300_3000},
        '{idx: PeriphSocCtrl, start_addr: 32'h0300_0000, end_addr: 32'h0300_1000},
        '{idx: PeriphDebug,   start_addr: 32'h0000_0000, end_addr: 32'h0004_0000}
    };

endpackage

// File: rtl/obi_err_sbr.sv
// OBI error subordinate: grants every request and answers one cycle later with
// an error response that echoes the request id. Write data is never looked at.
module obi_err_sbr #(
    parameter int unsigned IdWidth  = 1,
    parameter logic [31:0] ErrRdata = croc_pkg::ObiErrRdata
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic [IdWidth-1:0] aid_i,
    output logic               gnt_o,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic [IdWidth-1:0] rid_o,
    output logic               err_o
);

    logic               err_vld_d, err_vld_q;
    logic [IdWidth-1:0] err_id_d, err_id_q;

    always_comb begin
        err_vld_d = req_i;
        err_id_d  = req_i ? aid_i : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_vld_q <= 1'b0;
            err_id_q  <= '0;
        end else begin
            err_vld_q <= err_vld_d;
            err_id_q  <= err_id_d;
        end
    end

    always_comb begin
        gnt_o    = 1'b1;
        rvalid_o = err_vld_q;
        rdata_o  = err_vld_q ? ErrRdata : '0;
        rid_o    = err_id_q;
        err_o    = err_vld_q;
    end

endmodule

// File: rtl/obi_rule_demux.sv
// Single-manager OBI demultiplexer driven by an address rule table, with an
// internal error subordinate and in-order response tracking across targets.
module obi_rule_demux
    import croc_pkg::*;
#(
    parameter int unsigned NumRules       = 5,
    parameter int unsigned NumSbr         = 6,
    parameter addr_map_rule_t [NumRules-1:0] AddrMap = croc_pkg::periph_addr_map,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdWidth        = 1,
    parameter logic [31:0] ErrRdata       = croc_pkg::ObiErrRdata,
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumSbr-1:0]                  sbr_en_i,
    input  logic                               mgr_req_i,
    input  logic [31:0]                        mgr_addr_i,
    input  logic                               mgr_we_i,
    input  logic [3:0]                         mgr_be_i,
    input  logic [31:0]                        mgr_wdata_i,
    input  logic [IdWidth-1:0]                 mgr_aid_i,
    output logic                               mgr_gnt_o,
    output logic                               mgr_rvalid_o,
    output logic [31:0]                        mgr_rdata_o,
    output logic [IdWidth-1:0]                 mgr_rid_o,
    output logic                               mgr_err_o,
    output logic [NumSbr-2:0]                  sbr_req_o,
    output logic [31:0]                        sbr_addr_o,
    output logic                               sbr_we_o,
    output logic [3:0]                         sbr_be_o,
    output logic [31:0]                        sbr_wdata_o,
    output logic [IdWidth-1:0]                 sbr_aid_o,
    input  logic [NumSbr-2:0]                  sbr_gnt_i,
    input  logic [NumSbr-2:0]                  sbr_rvalid_i,
    input  logic [NumSbr-2:0][31:0]            sbr_rdata_i,
    input  logic [NumSbr-2:0][IdWidth-1:0]     sbr_rid_i,
    input  logic [NumSbr-2:0]                  sbr_err_i,
    output logic [CntW-1:0]                    outstanding_o,
    output logic                               busy_o
);

    localparam int unsigned SelW = $clog2(NumSbr);
    localparam logic [SelW-1:0] SelOne = SelW'(1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    // Lowest-numbered matching rule wins; disabled or unmatched goes to index 0.
    function automatic logic [SelW-1:0] decode(input logic [31:0] addr,
                                               input logic [NumSbr-1:0] en);
        logic [SelW-1:0] t;
        logic            hit;
        t   = '0;
        hit = 1'b0;
        for (int unsigned r = 0; r < NumRules; r++) begin
            if (!hit && addr >= AddrMap[r].start_addr && addr < AddrMap[r].end_addr) begin
                hit = 1'b1;
                t   = AddrMap[r].idx[SelW-1:0];
            end
        end
        if (t != '0 && !en[t]) begin
            t = '0;
        end
        return t;
    endfunction

    logic [CntW-1:0]    cnt_d, cnt_q;
    logic [SelW-1:0]    sel_d, sel_q;
    logic [SelW-1:0]    tgt, tgt_m1, sel_m1;
    logic               fwd, acc, rsp, rsp_raw;
    logic               err_req, err_gnt, err_rvalid, err_err;
    logic [31:0]        err_rdata, rsp_data;
    logic [IdWidth-1:0] err_rid, rsp_id;
    logic               rsp_err;
    logic [NumSbr-2:0]  sel_mask;

    assign sbr_addr_o  = mgr_addr_i;
    assign sbr_we_o    = mgr_we_i;
    assign sbr_be_o    = mgr_be_i;
    assign sbr_wdata_o = mgr_wdata_i;
    assign sbr_aid_o   = mgr_aid_i;

    obi_err_sbr #(
        .IdWidth  (IdWidth),
        .ErrRdata (ErrRdata)
    ) u_err_sbr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (err_req),
        .aid_i    (mgr_aid_i),
        .gnt_o    (err_gnt),
        .rvalid_o (err_rvalid),
        .rdata_o  (err_rdata),
        .rid_o    (err_rid),
        .err_o    (err_err)
    );

    // Request path: a target switch waits until every earlier response is back.
    always_comb begin
        tgt       = decode(mgr_addr_i, sbr_en_i);
        tgt_m1    = tgt - SelOne;
        fwd       = !rst_i && mgr_req_i &&
                    (cnt_q == '0 || (tgt == sel_q && cnt_q < CntMax));
        err_req   = fwd && (tgt == '0);
        sbr_req_o = '0;
        mgr_gnt_o = 1'b0;
        if (fwd) begin
            if (tgt == '0) begin
                mgr_gnt_o = err_gnt;
            end else begin
                sbr_req_o[tgt_m1] = 1'b1;
                mgr_gnt_o         = sbr_gnt_i[tgt_m1];
            end
        end
        acc = mgr_gnt_o;
    end

    // Response path: only the subordinate holding sel_q may answer.
    always_comb begin
        sel_m1   = sel_q - SelOne;
        sel_mask = '0;
        rsp_raw  = 1'b0;
        rsp_data = '0;
        rsp_id   = '0;
        rsp_err  = 1'b0;
        if (sel_q == '0) begin
            rsp_raw  = err_rvalid;
            rsp_data = err_rdata;
            rsp_id   = err_rid;
            rsp_err  = err_err;
        end else begin
            sel_mask[sel_m1] = 1'b1;
            rsp_raw          = sbr_rvalid_i[sel_m1];
            rsp_data         = sbr_rdata_i[sel_m1];
            rsp_id           = sbr_rid_i[sel_m1];
            rsp_err          = sbr_err_i[sel_m1];
        end
        rsp          = !rst_i && rsp_raw && (cnt_q != '0);
        mgr_rvalid_o = rsp;
        mgr_rdata_o  = rsp ? rsp_data : '0;
        mgr_rid_o    = rsp ? rsp_id : '0;
        mgr_err_o    = rsp ? rsp_err : 1'b0;
    end

    always_comb begin
        sel_d = acc ? tgt : sel_q;
        cnt_d = cnt_q;
        if (acc && !rsp) begin
            cnt_d = cnt_q + CntOne;
        end else if (!acc && rsp) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    assign outstanding_o = rst_i ? '0 : cnt_q;
    assign busy_o        = !rst_i && (cnt_q != '0);

    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(rsp_raw && cnt_q == '0));

    a_no_stray_rvalid : assert property (@(posedge clk_i) disable iff (rst_i)
        (cnt_q != '0) |-> ((sbr_rvalid_i & ~sel_mask) == '0));

endmodule

// File: tb/tb_obi_rule_demux.sv
// Directed bench for obi_rule_demux against the default Croc peripheral map.
module tb_obi_rule_demux;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [5:0]        sbr_en_i;
    logic              mgr_req_i;
    logic [31:0]       mgr_addr_i;
    logic              mgr_we_i;
    logic [3:0]        mgr_be_i;
    logic [31:0]       mgr_wdata_i;
    logic [0:0]        mgr_aid_i;
    logic              mgr_gnt_o;
    logic              mgr_rvalid_o;
    logic [31:0]       mgr_rdata_o;
    logic [0:0]        mgr_rid_o;
    logic              mgr_err_o;
    logic [4:0]        sbr_req_o;
    logic [31:0]       sbr_addr_o;
    logic              sbr_we_o;
    logic [3:0]        sbr_be_o;
    logic [31:0]       sbr_wdata_o;
    logic [0:0]        sbr_aid_o;
    logic [4:0]        sbr_gnt_i;
    logic [4:0]        sbr_rvalid_i;
    logic [4:0][31:0]  sbr_rdata_i;
    logic [4:0][0:0]   sbr_rid_i;
    logic [4:0]        sbr_err_i;
    logic [2:0]        outstanding_o;
    logic              busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    obi_rule_demux u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sbr_en_i      (sbr_en_i),
        .mgr_req_i     (mgr_req_i),
        .mgr_addr_i    (mgr_addr_i),
        .mgr_we_i      (mgr_we_i),
        .mgr_be_i      (mgr_be_i),
        .mgr_wdata_i   (mgr_wdata_i),
        .mgr_aid_i     (mgr_aid_i),
        .mgr_gnt_o     (mgr_gnt_o),
        .mgr_rvalid_o  (mgr_rvalid_o),
        .mgr_rdata_o   (mgr_rdata_o),
        .mgr_rid_o     (mgr_rid_o),
        .mgr_err_o     (mgr_err_o),
        .sbr_req_o     (sbr_req_o),
        .sbr_addr_o    (sbr_addr_o),
        .sbr_we_o      (sbr_we_o),
        .sbr_be_o      (sbr_be_o),
        .sbr_wdata_o   (sbr_wdata_o),
        .sbr_aid_o     (sbr_aid_o),
        .sbr_gnt_i     (sbr_gnt_i),
        .sbr_rvalid_i  (sbr_rvalid_i),
        .sbr_rdata_i   (sbr_rdata_i),
        .sbr_rid_i     (sbr_rid_i),
        .sbr_err_i     (sbr_err_i),
        .outstanding_o (outstanding_o),
        .busy_o        (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [31:0] addr, input logic we, input logic aid);
        mgr_req_i   = 1'b1;
        mgr_addr_i  = addr;
        mgr_we_i    = we;
        mgr_aid_i   = aid;
        mgr_be_i    = 4'hF;
        mgr_wdata_i = 32'hC0FF_EE00;
    endtask

    task automatic clr();
        mgr_req_i    = 1'b0;
        mgr_addr_i   = '0;
        mgr_we_i     = 1'b0;
        mgr_aid_i    = '0;
        sbr_rvalid_i = '0;
        sbr_rdata_i  = '0;
        sbr_rid_i    = '0;
        sbr_err_i    = '0;
    endtask

    // Drive on the falling edge, look at outputs 1 ns later, well before the rise.
    task automatic step();
        @(negedge clk_i);
        clr();
    endtask

    localparam logic [31:0] AUart  = 32'h0300_2000;
    localparam logic [31:0] AGpio  = 32'h0300_5000;
    localparam logic [31:0] ATimer = 32'h0300_A000;
    localparam logic [31:0] ANone  = 32'h0400_0000;

    initial begin
        rst_i       = 1'b1;
        sbr_en_i    = 6'b111111;
        sbr_gnt_i   = 5'b11111;
        mgr_be_i    = '0;
        mgr_wdata_i = '0;
        clr();

        // Reset held: a live request must not leak through.
        step(); req(AUart, 1'b0, 1'b1); #1;
        check("rst_gnt",   32'(mgr_gnt_o), 32'd0);
        check("rst_req",   32'(sbr_req_o), 32'd0);
        check("rst_cnt",   32'(outstanding_o), 32'd0);
        check("rst_rvld",  32'(mgr_rvalid_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);

        // 1. Uart read with a two-cycle response.
        step(); rst_i = 1'b0; req(AUart, 1'b0, 1'b1); #1;
        check("t1_gnt",    32'(mgr_gnt_o), 32'd1);
        check("t1_req",    32'(sbr_req_o), 32'b00100);
        check("t1_addr",   sbr_addr_o, AUart);
        step(); #1;
        check("t1_cnt1",   32'(outstanding_o), 32'd1);
        check("t1_busy",   32'(busy_o), 32'd1);
        check("t1_norv",   32'(mgr_rvalid_o), 32'd0);
        step(); sbr_rvalid_i[2] = 1'b1; sbr_rdata_i[2] = 32'h1234_5678; sbr_rid_i[2] = 1'b1; #1;
        check("t1_rvld",   32'(mgr_rvalid_o), 32'd1);
        check("t1_rdata",  mgr_rdata_o, 32'h1234_5678);
        check("t1_rid",    32'(mgr_rid_o), 32'd1);
        check("t1_err",    32'(mgr_err_o), 32'd0);
        step(); #1;
        check("t1_cnt0",   32'(outstanding_o), 32'd0);
        check("t1_idle",   mgr_rdata_o, 32'd0);

        // 2. Unmapped address goes to the error responder.
        step(); req(ANone, 1'b0, 1'b0); #1;
        check("t2_req",    32'(sbr_req_o), 32'd0);
        check("t2_gnt",    32'(mgr_gnt_o), 32'd1);
        step(); #1;
        check("t2_rvld",   32'(mgr_rvalid_o), 32'd1);
        check("t2_err",    32'(mgr_err_o), 32'd1);
        check("t2_rdata",  mgr_rdata_o, 32'hBADC_AB1E);
        check("t2_rid",    32'(mgr_rid_o), 32'd0);
        step(); #1;
        check("t2_cnt0",   32'(outstanding_o), 32'd0);

        // 3. Uart disabled at runtime, then re-enabled.
        step(); sbr_en_i = 6'b110111; req(AUart + 32'd4, 1'b1, 1'b1); #1;
        check("t3_req_off", 32'(sbr_req_o), 32'd0);
        check("t3_gnt_off", 32'(mgr_gnt_o), 32'd1);
        step(); #1;
        check("t3_err_off", 32'(mgr_err_o), 32'd1);
        check("t3_rid_off", 32'(mgr_rid_o), 32'd1);
        step(); sbr_en_i = 6'b111111; req(AUart + 32'd4, 1'b1, 1'b0); #1;
        check("t3_req_on", 32'(sbr_req_o), 32'b00100);
        check("t3_gnt_on", 32'(mgr_gnt_o), 32'd1);
        step(); sbr_rvalid_i[2] = 1'b1; #1;
        check("t3_rvld_on", 32'(mgr_rvalid_o), 32'd1);
        check("t3_err_on", 32'(mgr_err_o), 32'd0);

        // 4. Fill the outstanding budget with Gpio reads.
        for (int i = 0; i < 4; i++) begin
            step(); req(AGpio, 1'b0, 1'b0); #1;
            check($sformatf("t4_gnt%0d", i), 32'(mgr_gnt_o), 32'd1);
        end
        step(); req(AGpio, 1'b0, 1'b0); #1;
        check("t4_full",    32'(outstanding_o), 32'd4);
        check("t4_stall",   32'(mgr_gnt_o), 32'd0);
        check("t4_noreq",   32'(sbr_req_o), 32'd0);
        step(); req(AGpio, 1'b0, 1'b0); sbr_rvalid_i[3] = 1'b1; #1;
        check("t4_rv_stall", 32'(mgr_gnt_o), 32'd0);
        check("t4_rv",      32'(mgr_rvalid_o), 32'd1);
        step(); req(AGpio, 1'b0, 1'b0); #1;
        check("t4_cnt3",    32'(outstanding_o), 32'd3);
        check("t4_gnt5",    32'(mgr_gnt_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(); sbr_rvalid_i[3] = 1'b1; #1;
            check($sformatf("t4_drain%0d", i), 32'(outstanding_o), 32'(4 - i));
        end
        step(); #1;
        check("t4_cnt0",    32'(outstanding_o), 32'd0);

        // 5. Target switch waits for the Gpio response.
        step(); req(AGpio, 1'b0, 1'b0); #1;
        check("t5_gpio_gnt", 32'(mgr_gnt_o), 32'd1);
        step(); req(ATimer, 1'b0, 1'b1); #1;
        check("t5_hold_gnt", 32'(mgr_gnt_o), 32'd0);
        check("t5_hold_req", 32'(sbr_req_o), 32'd0);
        step(); req(ATimer, 1'b0, 1'b1); sbr_rvalid_i[3] = 1'b1; sbr_rdata_i[3] = 32'hAAAA_0004; #1;
        check("t5_gpio_rd", mgr_rdata_o, 32'hAAAA_0004);
        check("t5_rv_gnt",  32'(mgr_gnt_o), 32'd0);
        step(); req(ATimer, 1'b0, 1'b1); #1;
        check("t5_tmr_req", 32'(sbr_req_o), 32'b10000);
        check("t5_tmr_gnt", 32'(mgr_gnt_o), 32'd1);
        step(); sbr_rvalid_i[4] = 1'b1; sbr_rdata_i[4] = 32'hBBBB_0005; sbr_rid_i[4] = 1'b1; #1;
        check("t5_tmr_rd",  mgr_rdata_o, 32'hBBBB_0005);
        check("t5_tmr_rid", 32'(mgr_rid_o), 32'd1);
        step(); #1;
        check("t5_cnt0",    32'(outstanding_o), 32'd0);

        // 6. Reset with two Gpio reads in flight.
        step(); req(AGpio, 1'b0, 1'b0);
        step(); req(AGpio, 1'b0, 1'b0);
        step(); #1;
        check("t6_cnt2",    32'(outstanding_o), 32'd2);
        rst_i = 1'b1; req(AGpio, 1'b0, 1'b0); sbr_rvalid_i[3] = 1'b1; #1;
        check("t6_rst_cnt", 32'(outstanding_o), 32'd0);
        check("t6_rst_gnt", 32'(mgr_gnt_o), 32'd0);
        check("t6_rst_rv",  32'(mgr_rvalid_o), 32'd0);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        step(); rst_i = 1'b0; sbr_rvalid_i[3] = 1'b1; #1;
        check("t6_stale_rv", 32'(mgr_rvalid_o), 32'd0);
        step(); #1;
        check("t6_cnt0",    32'(outstanding_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
